// File: rtl/uart_pkg.sv
// Shared constants and baud-divisor helpers for the UART transmitter.
// Divisors are derived from the system clock so CLK_HZ retargets the whole table.
package uart_pkg;

   localparam int BIT_COUNT = 8;
   localparam int DIV_W     = 13;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   function automatic int baud_rate(input logic [2:0] sel);
      int baud;
      case (sel)
         3'd0:    baud = 115_200;
         3'd1:    baud = 230_400;
         3'd2:    baud = 460_800;
         3'd3:    baud = 921_600;
         3'd4:    baud = 1_000_000;
         3'd5:    baud = 2_000_000;
         3'd6:    baud = 9_600;
         default: baud = 19_200;
      endcase
      return baud;
   endfunction

   // Rounded to nearest, so 460800 baud at 50 MHz gives 109 rather than 108.
   function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input logic [2:0] sel);
      int baud;
      baud = baud_rate(sel);
      return DIV_W'((clk_hz + baud / 2) / baud);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter: after load, emits a one-clock tick every div clocks while en is high.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] div,
   input  logic             en,
   output logic             tick
);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] reload;

   assign tick = en && (cnt == '0);

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cnt    <= '0;
         reload <= '0;
      end else if (load) begin
         cnt    <= div - WIDTH'(1);
         reload <= div - WIDTH'(1);
      end else if (en) begin
         cnt <= tick ? reload : cnt - WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter, LSB first, runtime baud select; rst_n is active-high despite its name.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and stop.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] baud_sel,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   logic [2:0]       state;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic             tx_q;
   logic             busy_q;
   logic             ready_q;
   logic             tick;
   logic             accept;
   logic [DIV_W-1:0] div_lut [8];
`ifdef UART_TX_PARITY_EN
   logic             parity_q;
`endif

   for (genvar g = 0; g < 8; g++) begin : g_div
      assign div_lut[g] = baud_div(CLK_HZ, 3'(g));
   end

   assign accept = (state == IDLE) && start;

   uart_baud_tick #(.WIDTH(DIV_W)) u_baud_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .div   (div_lut[baud_sel]),
      .en    (busy_q),
      .tick  (tick)
   );

   // NOTE: the byte buffer is reset along with the control state; it is a single register, not a memory.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg   <= data;
                  bit_idx <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state   <= START;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^data;
`endif
               end
            end
            START: begin
               if (tick) begin
                  tx_q  <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == 3'(BIT_COUNT - 1)) begin
`ifdef UART_TX_PARITY_EN
                     tx_q  <= parity_q;
                     state <= PARITY;
`else
                     tx_q  <= 1'b1;
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= shreg[bit_idx + 3'd1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  tx_q  <= 1'b1;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               // start is deliberately not looked at here, even on the closing tick.
               if (tick) begin
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

   assign tx    = tx_q;
   assign busy  = busy_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core; expected tx patterns are hand-written per frame.
// Honours UART_TX_PARITY_EN to expect the 11-bit framing.
`timescale 1ns/1ps
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [2:0] baud_sel = 3'd0;
   logic [7:0] data = 8'h00;
   logic       ready;
   logic       tx;
   logic       busy;

   int n_checks = 0;
   int n_fails  = 0;

`ifdef UART_TX_PARITY_EN
   localparam int          NB  = 11;
   localparam logic [10:0] P55 = 11'b10010101010;
   localparam logic [10:0] PAA = 11'b10101010100;
   localparam logic [10:0] PEF = 11'b11111011110;
   localparam logic [10:0] P07 = 11'b11000001110;
`else
   localparam int          NB  = 10;
   localparam logic [10:0] P55 = 11'b01010101010;
   localparam logic [10:0] PAA = 11'b01101010100;
   localparam logic [10:0] PEF = 11'b01111011110;
   localparam logic [10:0] P07 = 11'b01000001110;
`endif

   uart_tx_core #(.CLK_HZ(50_000_000)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .baud_sel (baud_sel),
      .data     (data),
      .ready    (ready),
      .tx       (tx),
      .busy     (busy)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Sends one frame and samples tx on the first and last clock of every bit period.
   // inj_n >= 0 pulses start (with inj_d) for one clock at that cycle offset of the frame.
   task automatic run_frame(input string name, input logic [7:0] d, input logic [2:0] sel,
                            input int div, input logic [10:0] pat, input int inj_n,
                            input logic [7:0] inj_d);
      int k;
      int r;
      @(negedge clk);
      data = d; baud_sel = sel; start = 1'b1;
      @(negedge clk);
      start = 1'b0; data = ~d; baud_sel = ~sel;
      for (int n = 0; n <= NB * div; n++) begin
         if (n > 0) @(negedge clk);
         k = n / div;
         r = n % div;
         if (k < NB && (r == 0 || r == div - 1))
            check($sformatf("%s tx bit%0d c%0d", name, k, r), 32'(tx), 32'(pat[k]));
         if (n == 0) begin
            check({name, " busy at accept"}, 32'(busy), 32'd1);
            check({name, " ready at accept"}, 32'(ready), 32'd0);
         end
         if (n == NB * div - 1) check({name, " busy last cycle"}, 32'(busy), 32'd1);
         if (n == NB * div) begin
            check({name, " busy after frame"}, 32'(busy), 32'd0);
            check({name, " ready after frame"}, 32'(ready), 32'd1);
         end
         if (n == inj_n) begin
            start = 1'b1; data = inj_d;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic check_idle(input string name, input int cycles);
      int busy_seen = 0;
      int tx_low = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (busy) busy_seen++;
         if (!tx) tx_low++;
      end
      check({name, " idle busy cycles"}, 32'(busy_seen), 32'd0);
      check({name, " idle tx low cycles"}, 32'(tx_low), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset tx", 32'(tx), 32'd1);
      check("reset busy", 32'(busy), 32'd0);
      check("reset ready", 32'(ready), 32'd1);

      // start present while reset is still asserted on the edge: must not be taken
      data = 8'h55; baud_sel = 3'd5; start = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0; start = 1'b0;
      @(negedge clk);
      check("reset+start busy", 32'(busy), 32'd0);
      check_idle("reset+start", 30);

      run_frame("f55", 8'h55, 3'd1, 217, P55, 5 * 217 + 3, 8'h00);
      check_idle("f55", 3 * 217);

      run_frame("fAA", 8'hAA, 3'd2, 109, PAA, -1, 8'h00);
      check_idle("fAA", 20);

      run_frame("fEF", 8'hEF, 3'd3, 54, PEF, NB * 54 - 1, 8'h00);
      check_idle("fEF", 3 * 54);

      run_frame("f07", 8'h07, 3'd5, 25, P07, -1, 8'h00);
      check_idle("f07", 10);

      // asynchronous reset during the start bit
      @(negedge clk);
      data = 8'hEF; baud_sel = 3'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("midreset tx before", 32'(tx), 32'd0);
      rst_n = 1'b1;
      #1;
      check("midreset tx async", 32'(tx), 32'd1);
      check("midreset busy async", 32'(busy), 32'd0);
      check("midreset ready async", 32'(ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      check_idle("midreset", 60);

      run_frame("f55b", 8'h55, 3'd5, 25, P55, -1, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
